// File: rtl/display_source_scheduler.sv
// Display source scheduler: drives the 7-line display mux select.
// Alternates sources "n" (0) and "r" (1) on a dwell timer and blanks the
// display around each swap. A debounced button forces an early swap, and
// the alarm input pins the display to ALARM_SRC.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// SHOW_N    | source n shown, dwell timer runs while enable=1
// SHOW_R    | source r shown, dwell timer runs while enable=1
// BLANK     | display forced off, selector already on the new target
// ALARM     | display pinned to ALARM_SRC until alarm drops
module display_source_scheduler #(
    parameter int DWELL_CYCLES    = 50_000_000,
    parameter int BLANK_CYCLES    = 1_000,
    parameter int DEBOUNCE_CYCLES = 500_000,
    parameter bit ALARM_SRC       = 1'b1
) (
    input  logic clock,
    input  logic reset_n,
    input  logic enable,
    input  logic btn_raw,
    input  logic alarm,
    output logic selector,
    output logic blank,
    output logic switch_pulse
);

    localparam int DWELL_W = (DWELL_CYCLES > 1)    ? $clog2(DWELL_CYCLES)    : 1;
    localparam int BLANK_W = (BLANK_CYCLES > 1)    ? $clog2(BLANK_CYCLES)    : 1;
    localparam int DB_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL_CYCLES - 1);
    localparam logic [BLANK_W-1:0] BLANK_LAST = BLANK_W'(BLANK_CYCLES - 1);
    localparam logic [DB_W-1:0]    DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_SHOW_N = 2'd0,
        ST_SHOW_R = 2'd1,
        ST_BLANK  = 2'd2,
        ST_ALARM  = 2'd3
    } state_t;

    // Button path signals
    logic            sync1_q, sync1_d;
    logic            sync2_q, sync2_d;
    logic            db_level_q, db_level_d;
    logic [DB_W-1:0] db_cnt_q, db_cnt_d;
    logic            press_q, press_d;

    // Scheduler signals
    state_t             state_q, state_d;
    logic               target_q, target_d;
    logic               selector_q, selector_d;
    logic               blank_q, blank_d;
    logic               switch_pulse_q, switch_pulse_d;
    logic [DWELL_W-1:0] dwell_cnt_q, dwell_cnt_d;
    logic [BLANK_W-1:0] blank_cnt_q, blank_cnt_d;

    logic show_src;
    logic dwell_done;

    // Synchronise the raw button, debounce it, and derive the press pulse
    always_comb begin
        sync1_d    = btn_raw;
        sync2_d    = sync1_q;
        db_level_d = db_level_q;
        db_cnt_d   = '0;
        if (sync2_q != db_level_q) begin
            if (db_cnt_q == DB_LAST) begin
                db_level_d = sync2_q;
            end else begin
                db_cnt_d = db_cnt_q + DB_W'(1);
            end
        end
        press_d = db_level_d & ~db_level_q;
    end

    // Button path registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            db_level_q <= 1'b0;
            db_cnt_q   <= '0;
            press_q    <= 1'b0;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            db_level_q <= db_level_d;
            db_cnt_q   <= db_cnt_d;
            press_q    <= press_d;
        end
    end

    assign show_src   = (state_q == ST_SHOW_R);
    assign dwell_done = enable && (dwell_cnt_q == DWELL_LAST);

    // Next state and registered outputs; alarm overrides everything else
    always_comb begin
        state_d        = state_q;
        target_d       = target_q;
        selector_d     = selector_q;
        blank_d        = blank_q;
        switch_pulse_d = 1'b0;
        dwell_cnt_d    = dwell_cnt_q;
        blank_cnt_d    = blank_cnt_q;

        if (alarm) begin
            if (state_q != ST_ALARM) begin
                state_d        = ST_ALARM;
                switch_pulse_d = (selector_q != ALARM_SRC);
                dwell_cnt_d    = '0;
                blank_cnt_d    = '0;
            end
            selector_d = ALARM_SRC;
            blank_d    = 1'b0;
        end else begin
            case (state_q)
                ST_SHOW_N, ST_SHOW_R: begin
                    // press and dwell expiry collapse into a single swap
                    if (press_q || dwell_done) begin
                        state_d        = ST_BLANK;
                        target_d       = ~show_src;
                        selector_d     = ~show_src;
                        blank_d        = 1'b1;
                        switch_pulse_d = 1'b1;
                        dwell_cnt_d    = '0;
                        blank_cnt_d    = '0;
                    end else if (enable) begin
                        dwell_cnt_d = dwell_cnt_q + DWELL_W'(1);
                    end
                end
                ST_BLANK: begin
                    if (blank_cnt_q == BLANK_LAST) begin
                        state_d     = target_q ? ST_SHOW_R : ST_SHOW_N;
                        selector_d  = target_q;
                        blank_d     = 1'b0;
                        dwell_cnt_d = '0;
                        blank_cnt_d = '0;
                    end else begin
                        blank_cnt_d = blank_cnt_q + BLANK_W'(1);
                    end
                end
                ST_ALARM: begin
                    // leaving the alarm keeps the pinned source, so no pulse
                    state_d     = ALARM_SRC ? ST_SHOW_R : ST_SHOW_N;
                    selector_d  = ALARM_SRC;
                    blank_d     = 1'b0;
                    dwell_cnt_d = '0;
                    blank_cnt_d = '0;
                end
                default: begin
                    state_d     = ST_SHOW_N;
                    selector_d  = 1'b0;
                    blank_d     = 1'b0;
                    dwell_cnt_d = '0;
                    blank_cnt_d = '0;
                end
            endcase
        end
    end

    // Scheduler state and output registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= ST_SHOW_N;
            target_q       <= 1'b0;
            selector_q     <= 1'b0;
            blank_q        <= 1'b0;
            switch_pulse_q <= 1'b0;
            dwell_cnt_q    <= '0;
            blank_cnt_q    <= '0;
        end else begin
            state_q        <= state_d;
            target_q       <= target_d;
            selector_q     <= selector_d;
            blank_q        <= blank_d;
            switch_pulse_q <= switch_pulse_d;
            dwell_cnt_q    <= dwell_cnt_d;
            blank_cnt_q    <= blank_cnt_d;
        end
    end

    assign selector     = selector_q;
    assign blank        = blank_q;
    assign switch_pulse = switch_pulse_q;

endmodule

// File: tb/tb_display_source_scheduler.sv
// Bench for display_source_scheduler: directed scenarios followed by a
// randomized run, all checked every cycle against a behavioural model.
module tb_display_source_scheduler;

    localparam int DWELL     = 8;
    localparam int BLANKC    = 2;
    localparam int DEBOUNCE  = 4;
    localparam bit ASRC      = 1'b1;

    localparam int M_SHOW  = 0;
    localparam int M_BLANK = 1;
    localparam int M_ALARM = 2;

    logic clock;
    logic reset_n;
    logic enable;
    logic btn_raw;
    logic alarm;
    logic selector;
    logic blank;
    logic switch_pulse;

    int checks   = 0;
    int failures = 0;
    int pulse_cnt = 0;

    // Behavioural model state
    int m_mode;
    int m_left;     // cycles left in the current show/blank period
    bit m_sel;
    bit m_blank;
    bit m_pulse;
    bit m_s1, m_s2, m_level, m_press;
    int m_run;

    display_source_scheduler #(
        .DWELL_CYCLES   (DWELL),
        .BLANK_CYCLES   (BLANKC),
        .DEBOUNCE_CYCLES(DEBOUNCE),
        .ALARM_SRC      (ASRC)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .enable      (enable),
        .btn_raw     (btn_raw),
        .alarm       (alarm),
        .selector    (selector),
        .blank       (blank),
        .switch_pulse(switch_pulse)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic model_reset();
        m_mode  = M_SHOW;
        m_left  = DWELL;
        m_sel   = 1'b0;
        m_blank = 1'b0;
        m_pulse = 1'b0;
        m_s1    = 1'b0;
        m_s2    = 1'b0;
        m_level = 1'b0;
        m_press = 1'b0;
        m_run   = 0;
    endtask

    // One clock edge of the model, using the inputs present at that edge
    task automatic model_step();
        bit old_press;
        bit old_s2;
        old_press = m_press;
        old_s2    = m_s2;
        m_pulse   = 1'b0;
        if (alarm) begin
            if (m_mode != M_ALARM) begin
                m_pulse = (m_sel != ASRC);
                m_sel   = ASRC;
                m_blank = 1'b0;
                m_mode  = M_ALARM;
            end
        end else if (m_mode == M_ALARM) begin
            m_mode = M_SHOW;
            m_left = DWELL;
        end else if (m_mode == M_SHOW) begin
            if (old_press || (enable && m_left == 1)) begin
                m_mode  = M_BLANK;
                m_sel   = !m_sel;
                m_blank = 1'b1;
                m_pulse = 1'b1;
                m_left  = BLANKC;
            end else if (enable) begin
                m_left--;
            end
        end else begin
            m_left--;
            if (m_left == 0) begin
                m_mode  = M_SHOW;
                m_left  = DWELL;
                m_blank = 1'b0;
            end
        end
        m_press = 1'b0;
        if (old_s2 != m_level) begin
            m_run++;
            if (m_run == DEBOUNCE) begin
                m_level = old_s2;
                m_run   = 0;
                m_press = m_level;
            end
        end else begin
            m_run = 0;
        end
        m_s2 = m_s1;
        m_s1 = btn_raw;
    endtask

    task automatic check(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d t=%0t", tag, obs, exp, $time);
        end
    endtask

    // Advance one cycle and compare all outputs against the model
    task automatic tick();
        @(posedge clock);
        if (reset_n) model_step();
        #1;
        check("selector", selector, m_sel);
        check("blank", blank, m_blank);
        check("switch_pulse", switch_pulse, m_pulse);
        if (switch_pulse === 1'b1) pulse_cnt++;
    endtask

    initial begin
        bit found;
        bit btn_lvl;
        int hold;

        reset_n = 1'b0;
        enable  = 1'b0;
        btn_raw = 1'b0;
        alarm   = 1'b0;
        model_reset();

        // Reset state
        repeat (3) tick();
        check("rst_selector", selector, 1'b0);
        check("rst_blank", blank, 1'b0);

        // 1: free-running dwell and blank
        reset_n = 1'b1;
        enable  = 1'b1;
        pulse_cnt = 0;
        repeat (17) tick();
        check_int("dwell_pulses", pulse_cnt, 1);
        check("dwell_sel_r", selector, 1'b1);

        // 2: held button gives exactly one swap
        enable = 1'b0;
        pulse_cnt = 0;
        btn_raw = 1'b1;
        repeat (10) tick();
        btn_raw = 1'b0;
        repeat (10) tick();
        check_int("btn_hold_pulses", pulse_cnt, 1);
        check("btn_hold_sel_n", selector, 1'b0);

        // 2: short glitches are rejected
        pulse_cnt = 0;
        repeat (4) begin
            btn_raw = 1'b1;
            repeat (3) tick();
            btn_raw = 1'b0;
            repeat (3) tick();
        end
        repeat (8) tick();
        check_int("glitch_pulses", pulse_cnt, 0);

        // 3: alarm during SHOW_N pins to r
        pulse_cnt = 0;
        alarm = 1'b1;
        tick();
        check("alarm_sel", selector, 1'b1);
        check("alarm_blank", blank, 1'b0);
        repeat (49) tick();
        check_int("alarm_pulses", pulse_cnt, 1);
        alarm  = 1'b0;
        enable = 1'b1;
        pulse_cnt = 0;
        repeat (8) tick();
        check_int("alarm_exit_dwell_pulses", pulse_cnt, 0);

        // 4: alarm aborts a blank heading toward n
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            tick();
            if (m_mode == M_BLANK && m_sel == 1'b0) found = 1'b1;
        end
        check("wait_blank_to_n", found, 1'b1);
        alarm = 1'b1;
        tick();
        check("abort_sel", selector, 1'b1);
        check("abort_blank", blank, 1'b0);

        // 5: frozen dwell timer
        alarm  = 1'b0;
        enable = 1'b0;
        pulse_cnt = 0;
        repeat (100) tick();
        check_int("frozen_pulses", pulse_cnt, 0);
        check("frozen_sel", selector, 1'b1);

        // 5: press lands on the same edge as dwell expiry
        enable = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            if (m_mode == M_BLANK) found = 1'b1;
        end
        check("wait_blank", found, 1'b1);
        found = 1'b0;
        for (int i = 0; i < 5 && !found; i++) begin
            tick();
            if (m_mode == M_SHOW) found = 1'b1;
        end
        check("wait_show", found, 1'b1);
        tick();
        btn_raw = 1'b1;
        pulse_cnt = 0;
        repeat (12) tick();
        check_int("coincide_pulses", pulse_cnt, 1);
        btn_raw = 1'b0;
        repeat (10) tick();

        // 6: async reset in the middle of a blank toward r
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            tick();
            if (m_mode == M_BLANK && m_sel == 1'b1) found = 1'b1;
        end
        check("wait_blank_to_r", found, 1'b1);
        #3;
        reset_n = 1'b0;
        #1;
        model_reset();
        check("async_rst_sel", selector, 1'b0);
        check("async_rst_blank", blank, 1'b0);
        check("async_rst_pulse", switch_pulse, 1'b0);
        repeat (2) tick();
        reset_n = 1'b1;

        // Randomized run
        btn_lvl = 1'b0;
        hold = 0;
        for (int i = 0; i < 3000; i++) begin
            if (hold == 0) begin
                btn_lvl = $urandom_range(0, 1) == 1;
                hold = $urandom_range(1, 12);
            end
            hold--;
            btn_raw = btn_lvl;
            enable  = $urandom_range(0, 9) != 0;
            if ($urandom_range(0, 39) == 0) alarm = !alarm;
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
